ccr_unit: RTL and testbench
===========================

Name: ccr_unit

Overview:
- Condition-code register (CCR) that receives the per-operation flags C/Z/N/V from the 8-bit ALU and holds the architectural flag state.
- Applies per-opcode flag-update masks, SETC/CLRC, conditional-branch evaluation with flag clear-on-taken, and interrupt save/restore of flags through a one-deep shadow register.
- Sits between the ALU flag outputs and the control unit / PC-select logic.

Parameters:
NFLAGS, 4, number of flag bits; fixed encoding Z=bit0, N=bit1, C=bit2, V=bit3.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result this cycle is committed
alu_c  in  1  ALU carry/borrow
alu_z  in  1  ALU zero
alu_n  in  1  ALU negative
alu_v  in  1  ALU overflow
flag_mask  in  4  per-flag write enable for the ALU update, bit order as CCR
setc  in  1  force C=1
clrc  in  1  force C=0
br_valid  in  1  conditional-branch evaluation request
br_cond  in  2  00=Z, 01=N, 10=C, 11=V
br_taken  out  1  combinational: br_valid AND selected ccr bit
int_save  in  1  interrupt entry: save flags
int_restore  in  1  RTI: restore flags
ccr  out  4  architectural flags (registered)
isr_active  out  1  shadow holds saved flags
seq_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at a clock edge):
  - ccr=0, shadow=0, isr_active=0, seq_err=0.
  - br_taken follows its equation, so it is 0 after reset because ccr=0.
- br_taken:
  - Zero latency; evaluated from the registered ccr, never from same-cycle ALU flags.
- Next-ccr computation, in this order:
  1. Start from the current ccr.
  2. If alu_valid=1, each bit whose flag_mask bit is 1 takes the corresponding alu_* value.
  3. If br_taken=1, the selected flag is cleared, but only if that bit was not written in step 2.
  4. setc forces C=1; clrc forces C=0. If setc and clrc are both 1, C keeps its step-3 value and seq_err is set.
  5. If int_restore is accepted, ccr=shadow and steps 1-4 are discarded.
- Interrupt state machine, two states, IDLE (isr_active=0) and IN_ISR (isr_active=1):
  - IDLE + int_save: shadow<=current ccr (the pre-update value); the ccr update from steps 1-4 still applies; go to IN_ISR.
  - IN_ISR + int_restore: ccr<=shadow; go to IDLE.
  - IN_ISR + int_save: nesting is not supported. seq_err<=1; shadow and state are unchanged.
  - IDLE + int_restore: seq_err<=1; ccr follows steps 1-4; state is unchanged.
  - int_save and int_restore in the same cycle: both are ignored, seq_err<=1, steps 1-4 apply.
- seq_err is cleared only by rst.
- Inputs are sampled every cycle; there is no backpressure.
- All outputs are registered except br_taken.

Decomposition:
- Package ccr_pkg:
  - Flag index constants: FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
  - Branch condition encodings: BR_Z, BR_N, BR_C, BR_V.
  - State encoding: ST_IDLE, ST_IN_ISR.
  - Opcode-to-flag_mask constants used by the control unit: ADD/SUB=4'b1111, AND/OR/NOT/NEG=4'b0011, RLC/RRC=4'b0111, INC/DEC=4'b1111.
- Sub-module ccr_cond_eval: combinational mux from ccr and br_cond to the selected bit. It is reused by the control unit for static checks.

Test Plan:
- Masked update: rst, then alu_valid=1, flags C=1,Z=1,N=1,V=1, flag_mask=4'b0011 -> next cycle ccr=4'b0011 (Z,N set; C,V stay 0).
- Branch clear-on-taken: ccr=4'b0001, br_valid=1, br_cond=00 -> br_taken=1 in the same cycle; next cycle ccr=0. Repeat with br_cond=01 -> br_taken=0, ccr unchanged.
- ALU write beats branch clear: ccr=4'b0001, br_valid=1, br_cond=00, alu_valid=1, alu_z=1, mask=4'b0001 -> br_taken=1, next ccr=4'b0001.
- SETC/CLRC: setc=1 -> ccr[2]=1. Then setc=clrc=1 -> ccr[2] unchanged, seq_err=1.
- Save/restore: ccr=4'b1010, int_save=1 with alu update mask=4'b1111 to 4'b0101 -> ccr=4'b0101, isr_active=1. Then int_restore=1 with alu_valid=1 -> ccr=4'b1010, isr_active=0.
- Errors and reset mid-ISR: int_save twice -> seq_err=1, shadow holds the first value. int_restore in IDLE -> seq_err=1. rst while isr_active=1 -> next cycle ccr=0, isr_active=0, seq_err=0.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared definitions for the condition-code register: flag positions,
// branch-condition and interrupt-state encodings, and the per-opcode flag
// write masks that the control unit drives onto flag_mask.
package ccr_pkg;

   localparam int CCR_NFLAGS = 4;

   // Bit positions inside the CCR
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef logic [CCR_NFLAGS-1:0] flags_t;

   // Conditional-branch selector, one code per flag
   typedef enum logic [1:0] {
      BR_Z = 2'b00,
      BR_N = 2'b01,
      BR_C = 2'b10,
      BR_V = 2'b11
   } br_cond_e;

   // Interrupt shadow state: IN_ISR means the shadow holds saved flags
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_ISR = 1'b1
   } isr_state_e;

   // Flag write masks per opcode class, bit order {V,C,N,Z}
   localparam flags_t MASK_ADD = 4'b1111;
   localparam flags_t MASK_SUB = 4'b1111;
   localparam flags_t MASK_AND = 4'b0011;
   localparam flags_t MASK_OR  = 4'b0011;
   localparam flags_t MASK_NOT = 4'b0011;
   localparam flags_t MASK_NEG = 4'b0011;
   localparam flags_t MASK_RLC = 4'b0111;
   localparam flags_t MASK_RRC = 4'b0111;
   localparam flags_t MASK_INC = 4'b1111;
   localparam flags_t MASK_DEC = 4'b1111;
   localparam flags_t MASK_NONE = 4'b0000;

   // Opcode classes the control unit decodes into a flag mask
   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_NOT,
      OP_NEG,
      OP_RLC,
      OP_RRC,
      OP_INC,
      OP_DEC,
      OP_OTHER
   } alu_op_e;

   // Opcode class to flag write mask; non-ALU opcodes leave the CCR alone
   function automatic flags_t op_flag_mask(input alu_op_e op);
      flags_t m;
      case (op)
         OP_ADD:  m = MASK_ADD;
         OP_SUB:  m = MASK_SUB;
         OP_AND:  m = MASK_AND;
         OP_OR:   m = MASK_OR;
         OP_NOT:  m = MASK_NOT;
         OP_NEG:  m = MASK_NEG;
         OP_RLC:  m = MASK_RLC;
         OP_RRC:  m = MASK_RRC;
         OP_INC:  m = MASK_INC;
         OP_DEC:  m = MASK_DEC;
         default: m = MASK_NONE;
      endcase
      return m;
   endfunction

   // Pack the individual ALU flag wires into CCR bit order
   function automatic flags_t pack_flags(input logic c, input logic z,
                                         input logic n, input logic v);
      flags_t f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/ccr_cond_eval.sv
// Branch-condition selector: picks the CCR bit named by br_cond and also
// reports which bit that is as a one-hot mask. Purely combinational so the
// control unit can reuse it for static condition checks.
module ccr_cond_eval
   import ccr_pkg::*;
(
   input  logic [CCR_NFLAGS-1:0] ccr,
   input  logic [1:0]            br_cond,
   output logic                  sel_bit,
   output logic [CCR_NFLAGS-1:0] sel_mask
);

   // Select the flag bit and its one-hot position for the requested condition
   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves it unassigned and infers a latch.
      sel_bit  = 1'b0;
      sel_mask = '0;
      case (br_cond_e'(br_cond))
         BR_Z: begin
            sel_bit          = ccr[FLAG_Z];
            sel_mask[FLAG_Z] = 1'b1;
         end
         BR_N: begin
            sel_bit          = ccr[FLAG_N];
            sel_mask[FLAG_N] = 1'b1;
         end
         BR_C: begin
            sel_bit          = ccr[FLAG_C];
            sel_mask[FLAG_C] = 1'b1;
         end
         BR_V: begin
            sel_bit          = ccr[FLAG_V];
            sel_mask[FLAG_V] = 1'b1;
         end
         default: begin
            sel_bit  = 1'b0;
            sel_mask = '0;
         end
      endcase
   end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register. Merges masked ALU flag updates, branch
// clear-on-taken and SETC/CLRC into the architectural flags, and saves /
// restores them around an interrupt through a one-deep shadow register.
// Protocol misuse (nested save, stray restore, conflicting requests,
// SETC+CLRC together) raises a sticky seq_err until reset.
module ccr_unit
   import ccr_pkg::*;
#(
   parameter int NFLAGS = CCR_NFLAGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic              alu_c,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_v,
   input  logic [NFLAGS-1:0] flag_mask,
   input  logic              setc,
   input  logic              clrc,
   input  logic              br_valid,
   input  logic [1:0]        br_cond,
   output logic              br_taken,
   input  logic              int_save,
   input  logic              int_restore,
   output logic [NFLAGS-1:0] ccr,
   output logic              isr_active,
   output logic              seq_err
);

   isr_state_e state_q;
   isr_state_e state_d;
   flags_t     shadow_q;

   // Flag datapath intermediates, one per update stage
   flags_t alu_flags;
   flags_t alu_wr;
   flags_t after_alu;
   flags_t after_br;
   flags_t after_c;
   flags_t ccr_d;

   // Branch selection and interrupt request decode
   logic   cond_bit;
   flags_t cond_sel;
   logic   both_req;
   logic   save_req;
   logic   restore_req;
   logic   save_acc;
   logic   restore_acc;
   logic   carry_conflict;
   logic   proto_err;

   ccr_cond_eval u_cond_eval (
      .ccr      (ccr),
      .br_cond  (br_cond),
      .sel_bit  (cond_bit),
      .sel_mask (cond_sel)
   );

   // Branch outcome is taken from the registered flags only, never from
   // this cycle's ALU result
   assign br_taken = br_valid & cond_bit;

   // Interrupt requests: asserting both at once cancels both
   assign both_req    = int_save & int_restore;
   assign save_req    = int_save & ~int_restore;
   assign restore_req = int_restore & ~int_save;
   assign save_acc    = save_req    & (state_q == ST_IDLE);
   assign restore_acc = restore_req & (state_q == ST_IN_ISR);

   assign carry_conflict = setc & clrc;

   // Any protocol violation this cycle feeds the sticky error flag
   assign proto_err = both_req
                    | (save_req    & (state_q == ST_IN_ISR))
                    | (restore_req & (state_q == ST_IDLE))
                    | carry_conflict;

   // Next-flag computation: ALU write, branch clear, carry force, restore
   always_comb begin
      alu_flags = pack_flags(alu_c, alu_z, alu_n, alu_v);
      alu_wr    = alu_valid ? flag_mask : '0;

      // Masked ALU write
      after_alu = (ccr & ~alu_wr) | (alu_flags & alu_wr);

      // A taken branch clears its flag unless the ALU just wrote that bit
      after_br = after_alu;
      if (br_taken) begin
         after_br = after_alu & ~(cond_sel & ~alu_wr);
      end

      // SETC / CLRC; both together leaves C alone
      after_c = after_br;
      if (setc && !clrc) begin
         after_c[FLAG_C] = 1'b1;
      end else if (clrc && !setc) begin
         after_c[FLAG_C] = 1'b0;
      end

      // An accepted restore overrides everything above
      ccr_d = restore_acc ? shadow_q : after_c;
   end

   // Interrupt FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (save_acc)    state_d = ST_IN_ISR;
         ST_IN_ISR: if (restore_acc) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Interrupt FSM outputs, decoded straight from the state register
   always_comb begin
      isr_active = (state_q == ST_IN_ISR);
   end

   // Interrupt FSM state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Architectural flags, shadow copy and sticky error
   always_ff @(posedge clk) begin
      // NOTE: the shadow is reset as well even though it is only read after
      // a save, so a restore never exposes an X-valued flag.
      if (rst) begin
         ccr      <= '0;
         shadow_q <= '0;
         seq_err  <= 1'b0;
      end else begin
         ccr <= ccr_d;
         if (save_acc) begin
            shadow_q <= ccr;
         end
         if (proto_err) begin
            seq_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: directed scenarios plus a randomized
// run, all compared against a flag-level reference model of the CCR.
module tb_ccr_unit;

   logic       clk;
   logic       rst;
   logic       alu_valid;
   logic       alu_c;
   logic       alu_z;
   logic       alu_n;
   logic       alu_v;
   logic [3:0] flag_mask;
   logic       setc;
   logic       clrc;
   logic       br_valid;
   logic [1:0] br_cond;
   logic       br_taken;
   logic       int_save;
   logic       int_restore;
   logic [3:0] ccr;
   logic       isr_active;
   logic       seq_err;

   int tests_run = 0;
   int failed    = 0;

   // Reference model state
   logic [3:0] m_ccr    = 4'b0000;
   logic [3:0] m_shadow = 4'b0000;
   logic       m_isr    = 1'b0;
   logic       m_err    = 1'b0;

   ccr_unit dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_c       (alu_c),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .alu_v       (alu_v),
      .flag_mask   (flag_mask),
      .setc        (setc),
      .clrc        (clrc),
      .br_valid    (br_valid),
      .br_cond     (br_cond),
      .br_taken    (br_taken),
      .int_save    (int_save),
      .int_restore (int_restore),
      .ccr         (ccr),
      .isr_active  (isr_active),
      .seq_err     (seq_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one clock edge's worth of architectural rules to the model
   task automatic model_step();
      logic [3:0] nxt;
      logic [3:0] written;
      logic [3:0] alu_vals;
      int         sel;
      logic       taken;
      if (rst) begin
         m_ccr = 4'b0000; m_shadow = 4'b0000; m_isr = 1'b0; m_err = 1'b0;
         return;
      end
      alu_vals = {alu_v, alu_c, alu_n, alu_z};
      sel      = int'(br_cond);
      taken    = br_valid && m_ccr[sel];
      written  = alu_valid ? flag_mask : 4'b0000;
      nxt      = m_ccr;
      for (int i = 0; i < 4; i++) if (written[i]) nxt[i] = alu_vals[i];
      if (taken && !written[sel]) nxt[sel] = 1'b0;
      if (setc && clrc) m_err = 1'b1;
      else if (setc)    nxt[2] = 1'b1;
      else if (clrc)    nxt[2] = 1'b0;
      if (int_save && int_restore) begin
         m_err = 1'b1;
      end else if (int_save) begin
         if (m_isr) m_err = 1'b1;
         else begin m_shadow = m_ccr; m_isr = 1'b1; end
      end else if (int_restore) begin
         if (m_isr) begin nxt = m_shadow; m_isr = 1'b0; end
         else m_err = 1'b1;
      end
      m_ccr = nxt;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; alu_valid = 1'b0; alu_c = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
      alu_v = 1'b0; flag_mask = 4'b0000; setc = 1'b0; clrc = 1'b0;
      br_valid = 1'b0; br_cond = 2'b00; int_save = 1'b0; int_restore = 1'b0;
   endtask

   // One clock with the current inputs: br_taken checked before the edge,
   // registered outputs checked just after it against the model
   task automatic run_cycle(input string tag);
      logic exp_taken;
      #1;
      exp_taken = br_valid && m_ccr[br_cond];
      tests_run++;
      if (br_taken !== exp_taken) begin
         failed++;
         $display("FAIL %s br_taken: got %b expected %b", tag, br_taken, exp_taken);
      end
      @(posedge clk);
      model_step();
      #1;
      tests_run++;
      if (ccr !== m_ccr) begin
         failed++;
         $display("FAIL %s ccr: got %b expected %b", tag, ccr, m_ccr);
      end
      tests_run++;
      if (isr_active !== m_isr) begin
         failed++;
         $display("FAIL %s isr_active: got %b expected %b", tag, isr_active, m_isr);
      end
      tests_run++;
      if (seq_err !== m_err) begin
         failed++;
         $display("FAIL %s seq_err: got %b expected %b", tag, seq_err, m_err);
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      run_cycle("reset");
      rst = 1'b0;
   endtask

   // Write all four flags from a value in {V,C,N,Z} order
   task automatic load_ccr(input logic [3:0] val);
      idle_inputs();
      alu_valid = 1'b1; flag_mask = 4'b1111;
      {alu_v, alu_c, alu_n, alu_z} = val;
      run_cycle("load");
      idle_inputs();
   endtask

   task automatic expect_ccr(input string tag, input logic [3:0] exp);
      tests_run++;
      if (ccr !== exp) begin
         failed++;
         $display("FAIL %s ccr: got %b expected %b", tag, ccr, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (ccr !== 4'b0000 || isr_active !== 1'b0 || seq_err !== 1'b0 || br_taken !== 1'b0) begin
         failed++;
         $display("FAIL reset_state: got ccr=%b isr=%b err=%b br=%b expected all zero",
                  ccr, isr_active, seq_err, br_taken);
      end
   endtask

   task automatic test_masked_update();
      do_reset();
      alu_valid = 1'b1; alu_c = 1'b1; alu_z = 1'b1; alu_n = 1'b1; alu_v = 1'b1;
      flag_mask = 4'b0011;
      run_cycle("masked");
      expect_ccr("masked_update", 4'b0011);
      idle_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      load_ccr(4'b0001);
      br_valid = 1'b1; br_cond = 2'b00;
      #1;
      tests_run++;
      if (br_taken !== 1'b1) begin
         failed++;
         $display("FAIL branch_z_taken: got %b expected 1", br_taken);
      end
      run_cycle("branch_z");
      expect_ccr("branch_clear", 4'b0000);
      load_ccr(4'b0001);
      br_valid = 1'b1; br_cond = 2'b01;
      #1;
      tests_run++;
      if (br_taken !== 1'b0) begin
         failed++;
         $display("FAIL branch_n_not_taken: got %b expected 0", br_taken);
      end
      run_cycle("branch_n");
      expect_ccr("branch_no_clear", 4'b0001);
      idle_inputs();
   endtask

   task automatic test_alu_beats_branch();
      do_reset();
      load_ccr(4'b0001);
      br_valid = 1'b1; br_cond = 2'b00;
      alu_valid = 1'b1; alu_z = 1'b1; flag_mask = 4'b0001;
      run_cycle("alu_vs_branch");
      expect_ccr("alu_beats_branch", 4'b0001);
      idle_inputs();
   endtask

   task automatic test_setc_clrc();
      do_reset();
      setc = 1'b1;
      run_cycle("setc");
      expect_ccr("setc", 4'b0100);
      clrc = 1'b1;
      run_cycle("setc_clrc");
      expect_ccr("setc_clrc_hold", 4'b0100);
      tests_run++;
      if (seq_err !== 1'b1) begin
         failed++;
         $display("FAIL setc_clrc_err: got %b expected 1", seq_err);
      end
      idle_inputs();
      clrc = 1'b1;
      run_cycle("clrc");
      expect_ccr("clrc", 4'b0000);
      idle_inputs();
   endtask

   task automatic test_save_restore();
      do_reset();
      load_ccr(4'b1010);
      int_save = 1'b1; alu_valid = 1'b1; flag_mask = 4'b1111;
      {alu_v, alu_c, alu_n, alu_z} = 4'b0101;
      run_cycle("save");
      expect_ccr("save_update", 4'b0101);
      tests_run++;
      if (isr_active !== 1'b1) begin
         failed++;
         $display("FAIL save_isr_active: got %b expected 1", isr_active);
      end
      idle_inputs();
      int_restore = 1'b1; alu_valid = 1'b1; flag_mask = 4'b1111;
      {alu_v, alu_c, alu_n, alu_z} = 4'b1111;
      run_cycle("restore");
      expect_ccr("restore_value", 4'b1010);
      tests_run++;
      if (isr_active !== 1'b0 || seq_err !== 1'b0) begin
         failed++;
         $display("FAIL restore_state: got isr=%b err=%b expected 0 0", isr_active, seq_err);
      end
      idle_inputs();
   endtask

   task automatic test_errors();
      // Nested save keeps the first shadow
      do_reset();
      load_ccr(4'b0110);
      int_save = 1'b1;
      run_cycle("save1");
      load_ccr(4'b1001);
      int_save = 1'b1;
      run_cycle("save2");
      tests_run++;
      if (seq_err !== 1'b1 || isr_active !== 1'b1) begin
         failed++;
         $display("FAIL nested_save: got err=%b isr=%b expected 1 1", seq_err, isr_active);
      end
      idle_inputs();
      int_restore = 1'b1;
      run_cycle("restore_first");
      expect_ccr("shadow_first", 4'b0110);
      // Restore while idle
      do_reset();
      load_ccr(4'b0011);
      int_restore = 1'b1;
      run_cycle("stray_restore");
      expect_ccr("stray_restore_ccr", 4'b0011);
      tests_run++;
      if (seq_err !== 1'b1) begin
         failed++;
         $display("FAIL stray_restore_err: got %b expected 1", seq_err);
      end
      // Save and restore together are both ignored
      do_reset();
      int_save = 1'b1; int_restore = 1'b1;
      run_cycle("save_and_restore");
      tests_run++;
      if (seq_err !== 1'b1 || isr_active !== 1'b0) begin
         failed++;
         $display("FAIL both_req: got err=%b isr=%b expected 1 0", seq_err, isr_active);
      end
      // Reset in the middle of an ISR
      do_reset();
      load_ccr(4'b1100);
      int_save = 1'b1; setc = 1'b1; clrc = 1'b1;
      run_cycle("save_err");
      idle_inputs();
      rst = 1'b1;
      run_cycle("reset_in_isr");
      tests_run++;
      if (ccr !== 4'b0000 || isr_active !== 1'b0 || seq_err !== 1'b0) begin
         failed++;
         $display("FAIL reset_mid_isr: got ccr=%b isr=%b err=%b expected 0000 0 0",
                  ccr, isr_active, seq_err);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst         = ($urandom_range(0, 79) == 0);
         alu_valid   = $urandom_range(0, 1);
         {alu_v, alu_c, alu_n, alu_z} = 4'($urandom);
         flag_mask   = 4'($urandom);
         setc        = ($urandom_range(0, 5) == 0);
         clrc        = ($urandom_range(0, 5) == 0);
         br_valid    = $urandom_range(0, 1);
         br_cond     = 2'($urandom);
         int_save    = ($urandom_range(0, 7) == 0);
         int_restore = ($urandom_range(0, 7) == 0);
         run_cycle("random");
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_masked_update();
      test_branch();
      test_alu_beats_branch();
      test_setc_clrc();
      test_save_restore();
      test_errors();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
